// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy encoding and the named bundle
// widths each stage register is instantiated with.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  localparam int IF_ID_CTRL_W  = 1;
  localparam int ID_EX_CTRL_W  = 9;
  localparam int EX_MEM_CTRL_W = 4;
  localparam int MEM_WB_CTRL_W = 2;
  localparam int PIPE_DATA_W   = 32;
  localparam int STALL_CNT_W   = 16;

endpackage

// File: rtl/pipe_slot.sv
// One valid+ctrl+data holding register. Clear wins over load; contents are
// zeroed whenever the slot empties, so outputs read zero on a bubble.
module pipe_slot #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              vld,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              vld_p0;
  logic [CTRL_W-1:0] ctrl_p0;
  logic [DATA_W-1:0] data_p0;

  // slot register
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      vld_p0  <= 1'b0;
      ctrl_p0 <= '0;
      data_p0 <= '0;
    end else if (load) begin
      vld_p0  <= 1'b1;
      ctrl_p0 <= ld_ctrl;
      data_p0 <= ld_data;
    end
  end

  assign vld  = vld_p0;
  assign ctrl = ctrl_p0 & {CTRL_W{vld_p0}};
  assign data = data_p0 & {DATA_W{vld_p0}};

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, flush, bubble
// gating, optional two-entry skid buffer and a saturating stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = MEM_WB_CTRL_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = STALL_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  occ_e              state_q, state_d;
  logic              accept, emit;
  logic              main_vld, main_load, main_clear, main_from_skid;
  logic [CTRL_W-1:0] main_ctrl, main_ld_ctrl;
  logic [DATA_W-1:0] main_data, main_ld_data;
  logic              skid_vld, skid_load, skid_clear;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CNT_W-1:0]  stall_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign out_valid = main_vld;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_vld} + {1'b0, skid_vld};

  // occupancy state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= OCC_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    unique case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          main_load = 1'b1;
          state_d   = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (accept && !emit) begin
          skid_load = 1'b1;
          state_d   = OCC_FULL;
        end else if (accept) begin
          main_load = 1'b1;
        end else if (emit) begin
          main_clear = 1'b1;
          state_d    = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (emit) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
          state_d        = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    // flush squashes everything, including a same-cycle accept
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
      state_d    = OCC_EMPTY;
    end
  end

  assign main_ld_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_ld_data = main_from_skid ? skid_data : in_data;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (main_clear),
    .load    (main_load),
    .ld_ctrl (main_ld_ctrl),
    .ld_data (main_ld_data),
    .vld     (main_vld),
    .ctrl    (main_ctrl),
    .data    (main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;

      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (skid_clear),
        .load    (skid_load),
        .ld_ctrl (in_ctrl),
        .ld_data (in_data),
        .vld     (skid_vld),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
      );

      // registered ready breaks the backward path from out_ready
      always_ff @(posedge clk) begin
        if (!rst_n) in_ready_q <= 1'b1;
        else        in_ready_q <= (state_d != OCC_FULL);
      end
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      logic unused_skid;
      assign unused_skid = skid_load ^ skid_clear;
      assign skid_vld    = 1'b0;
      assign skid_ctrl   = '0;
      assign skid_data   = '0;
      assign in_ready    = !out_valid || out_ready;
    end
  endgenerate

  // stall counter: cleared by reset only, survives flush
  always_ff @(posedge clk) begin
    if (!rst_n)                       stall_cnt_q <= '0;
    else if (out_valid && !out_ready) stall_cnt_q <= sat_inc(stall_cnt_q);
  end

  assign stall_cycles = stall_cnt_q;

endmodule
